stk_seq_ctrl: RTL and testbench

// Instruction sequencer for the stack machine. Fetches instruction words from instruction

---
 rtl/stk_seq_ctrl_if.sv | 34 +++
 rtl/stk_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_stk_seq_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/stk_seq_ctrl_if.sv
// Control bus between the stack-machine sequencer, the instruction ROM and the
// execution units. The sequencer connects through the master modport and the
// ROM/units (or a testbench standing in for them) through the slave modport.
interface stk_seq_ctrl_if #(
    parameter int ADDR_LEN = 8,
    parameter int DATA_LEN = 8
);
    logic                  start;
    logic [DATA_LEN+3:0]   imem_data;
    logic [ADDR_LEN-1:0]   imem_addr;
    logic                  imem_r_en;
    logic [3:0]            ctrl_bus;
    logic [DATA_LEN-1:0]   addr_const;
    logic                  pp_en;
    logic                  pp_fin;
    logic                  alu_en;
    logic                  alu_fin;
    logic                  alu_zero;
    logic                  busy;
    logic                  halted;
    logic                  err;

    modport master (
        input  start, imem_data, pp_fin, alu_fin, alu_zero,
        output imem_addr, imem_r_en, ctrl_bus, addr_const,
               pp_en, alu_en, busy, halted, err
    );

    modport slave (
        output start, imem_data, pp_fin, alu_fin, alu_zero,
        input  imem_addr, imem_r_en, ctrl_bus, addr_const,
               pp_en, alu_en, busy, halted, err
    );
endinterface

// File: rtl/stk_seq_ctrl.sv
// Instruction sequencer for the stack machine: fetch, decode, dispatch to the
// push/pop unit or the ALU, wait for the unit's fin, handle JMP/JZ/HALT locally.
// Optional watchdog on the WAIT state is enabled by defining SEQ_WDT_EN.
module stk_seq_ctrl #(
    parameter int ADDR_LEN   = 8,
    parameter int DATA_LEN   = 8,
    parameter int WDT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rstn,
    stk_seq_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_HALT, S_ERR
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    // A zero limit would make the watchdog fire on the very first WAIT cycle.
    if (WDT_CYCLES < 1) begin : g_wdt_cfg_check
        $error("stk_seq_ctrl: WDT_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic [ADDR_LEN-1:0]   pc_q, pc_d;
    logic [DATA_LEN+3:0]   ir_q, ir_d;

    logic [3:0]            op;
    logic [DATA_LEN-1:0]   operand;
    logic [ADDR_LEN-1:0]   jmp_tgt;
    logic [ADDR_LEN-1:0]   pc_inc;
    logic                  is_pp;
    logic                  is_alu;
    logic                  sel_fin;
    logic                  wdt_expired;

    assign op      = ir_q[DATA_LEN+3:DATA_LEN];
    assign operand = ir_q[DATA_LEN-1:0];
    // Jump targets are the operand zero-extended or truncated to the PC width.
    assign jmp_tgt = ADDR_LEN'(operand);
    assign pc_inc  = pc_q + ADDR_LEN'(1);
    assign is_pp   = (op <= 4'd2);
    assign is_alu  = (op >= 4'd4) && (op <= 4'd7);
    // Only the unit that was dispatched may end the WAIT.
    assign sel_fin = is_pp ? bus.pp_fin : bus.alu_fin;

`ifdef SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_q, wdt_d;

    // Watchdog counts WAIT cycles and is cleared in every other state.
    always_comb begin
        wdt_d = '0;
        if (state_q == S_WAIT) begin
            wdt_d = wdt_q + WDT_W'(1);
        end
    end

    // Watchdog register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end

    assign wdt_expired = (state_q == S_WAIT) && (wdt_q == WDT_W'(WDT_CYCLES - 1));
    assign bus.err     = (state_q == S_ERR);
`else
    assign wdt_expired = 1'b0;
    assign bus.err     = 1'b0;
`endif

    // Next-state, PC and instruction-register logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = bus.imem_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_pp || is_alu) begin
                    state_d = S_WAIT;
                end else if (op == OP_JMP) begin
                    pc_d    = jmp_tgt;
                    state_d = S_FETCH;
                end else if (op == OP_JZ) begin
                    pc_d    = bus.alu_zero ? jmp_tgt : pc_inc;
                    state_d = S_FETCH;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_WAIT: begin
                if (sel_fin) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else if (wdt_expired) begin
                    state_d = S_ERR;
                end
            end
            default: begin
                // HALT and ERR are left only through reset.
            end
        endcase
    end

    // State, PC and instruction registers; reset drops every output at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // The decoded fields stay on the bus through EXEC and WAIT.
    assign bus.imem_addr  = pc_q;
    assign bus.imem_r_en  = (state_q == S_FETCH);
    assign bus.ctrl_bus   = op;
    assign bus.addr_const = operand;
    assign bus.pp_en      = (state_q == S_EXEC) && is_pp;
    assign bus.alu_en     = (state_q == S_EXEC) && is_alu;
    assign bus.busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                            (state_q == S_EXEC)  || (state_q == S_WAIT);
    assign bus.halted     = (state_q == S_HALT);
endmodule

// File: tb/tb_stk_seq_ctrl.sv
// Self-checking bench for stk_seq_ctrl: directed programs plus random programs,
// compared against an instruction-level model of the sequencer. Define
// SEQ_WDT_EN to also exercise the watchdog (WDT_CYCLES=8 here).
module tb_stk_seq_ctrl;
    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    logic [11:0] mem [256];

    stk_seq_ctrl_if #(.ADDR_LEN(8), .DATA_LEN(8)) ifc ();

    stk_seq_ctrl #(.ADDR_LEN(8), .DATA_LEN(8), .WDT_CYCLES(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM: one-cycle read latency.
    always @(posedge clk) begin
        if (ifc.imem_r_en) ifc.imem_data <= mem[ifc.imem_addr];
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        ifc.start     = 1'b0;
        ifc.pp_fin    = 1'b0;
        ifc.alu_fin   = 1'b0;
        ifc.alu_zero  = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        chk("rst_outs", {ifc.imem_addr, ifc.imem_r_en, ifc.ctrl_bus, ifc.addr_const,
                         ifc.pp_en, ifc.alu_en, ifc.busy, ifc.halted, ifc.err}, 32'h0);
        tick();
        chk("idle_stays", {ifc.busy, ifc.imem_r_en}, 32'h0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 12'h300;
    endtask

    // Runs the program in mem from pc=0; zmode 0/1 forces alu_zero, 2 randomizes.
    task automatic run_prog(input int max_instr, input int zmode);
        int          pc_m;
        int          n;
        bit          done;
        logic [11:0] w;
        logic [3:0]  op;
        logic [7:0]  opd;
        bit          is_pp, is_alu, zero;
        int          lat;
        pc_m = 0;
        n    = 0;
        done = 0;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'($urandom_range(0, 1));
        while (!done && n < max_instr) begin
            w      = mem[pc_m];
            op     = w[11:8];
            opd    = w[7:0];
            is_pp  = (op == 4'd0) || (op == 4'd1) || (op == 4'd2);
            is_alu = (op == 4'd4) || (op == 4'd5) || (op == 4'd6) || (op == 4'd7);
            chk("fetch_ren_busy", {ifc.imem_r_en, ifc.busy}, 32'h3);
            chk("fetch_addr", 32'(ifc.imem_addr), 32'(pc_m));
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            ifc.alu_zero = zero;
            tick();
            chk("decode_quiet", {ifc.pp_en, ifc.alu_en, ifc.imem_r_en, ifc.busy}, 32'h1);
            tick();
            // A fin already high in EXEC must not cut WAIT short.
            if (is_pp)  ifc.pp_fin  = 1'($urandom_range(0, 1));
            if (is_alu) ifc.alu_fin = 1'($urandom_range(0, 1));
            chk("exec_bus", {ifc.ctrl_bus, ifc.addr_const}, 32'(w));
            chk("exec_en", {ifc.pp_en, ifc.alu_en}, {30'd0, is_pp, is_alu});
            if (is_pp || is_alu) begin
                lat = $urandom_range(0, 3);
                tick();
                for (int i = 0; i < lat; i++) begin
                    // The unselected unit's fin is held high to prove it is ignored.
                    ifc.pp_fin  = !is_pp;
                    ifc.alu_fin = is_pp;
                    chk("wait_hold", {ifc.ctrl_bus, ifc.addr_const}, 32'(w));
                    chk("wait_state", {ifc.pp_en, ifc.alu_en, ifc.imem_r_en, ifc.busy}, 32'h1);
                    tick();
                end
                ifc.pp_fin  = 1'b1;
                ifc.alu_fin = 1'b1;
                chk("wait_last", {ifc.ctrl_bus, ifc.addr_const, ifc.imem_r_en}, {19'd0, w, 1'b0});
                tick();
                ifc.pp_fin  = 1'b0;
                ifc.alu_fin = 1'b0;
                pc_m = (pc_m + 1) % 256;
            end else if (op == 4'd8) begin
                pc_m = opd;
                tick();
            end else if (op == 4'd9) begin
                pc_m = zero ? int'(opd) : (pc_m + 1) % 256;
                tick();
            end else if (op == 4'd15) begin
                tick();
                chk("halt_flags", {ifc.halted, ifc.busy, ifc.imem_r_en}, 32'h4);
                chk("halt_pc", 32'(ifc.imem_addr), 32'(pc_m));
                ifc.start = 1'b1;
                repeat (3) tick();
                chk("halt_sticky", {ifc.halted, ifc.busy, ifc.imem_r_en}, 32'h4);
                done = 1;
            end else begin
                pc_m = (pc_m + 1) % 256;
                tick();
            end
            n++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ifc.imem_data = '0;

        // PUSHC 5; HALT
        clear_mem();
        mem[0] = 12'h005;
        mem[1] = 12'hF00;
        do_reset();
        run_prog(4, 0);
        $display("step pushc_halt checks=%0d failures=%0d", checks, failures);

        // PUSHM 3; ADD; HALT
        clear_mem();
        mem[0] = 12'h103;
        mem[1] = 12'h400;
        mem[2] = 12'hF00;
        do_reset();
        run_prog(5, 2);
        $display("step pushm_add_halt checks=%0d failures=%0d", checks, failures);

        // JZ 6 taken / not taken
        clear_mem();
        mem[0] = 12'h906;
        mem[1] = 12'hF00;
        mem[6] = 12'hF00;
        do_reset();
        run_prog(4, 1);
        do_reset();
        run_prog(4, 0);
        $display("step jz checks=%0d failures=%0d", checks, failures);

        // JMP 255 then NOP at 255 wraps to 0
        clear_mem();
        mem[0]   = 12'h8FF;
        mem[255] = 12'h300;
        do_reset();
        run_prog(3, 0);
        $display("step pc_wrap checks=%0d failures=%0d", checks, failures);

        // Reset in EXEC of a PUSHC: enables and bus drop at once, stale fin ignored
        clear_mem();
        mem[0] = 12'h005;
        mem[1] = 12'hF00;
        do_reset();
        ifc.start = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_pp_en", 32'(ifc.pp_en), 32'h1);
        rstn = 1'b0;
        #1;
        chk("async_rst_outs", {ifc.pp_en, ifc.alu_en, ifc.busy, ifc.ctrl_bus, ifc.addr_const}, 32'h0);
        ifc.start  = 1'b0;
        ifc.pp_fin = 1'b1;
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_idle", {ifc.busy, ifc.halted, ifc.imem_r_en}, 32'h0);
        ifc.pp_fin = 1'b0;
        run_prog(4, 0);
        $display("step reset_mid_exec checks=%0d failures=%0d", checks, failures);

`ifdef SEQ_WDT_EN
        // No fin after a PUSHC: err exactly 8 cycles after entering WAIT
        clear_mem();
        mem[0] = 12'h005;
        do_reset();
        ifc.start = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("wdt_wait0", {ifc.err, ifc.busy}, 32'h1);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("wdt_waitk", {ifc.err, ifc.busy}, 32'h1);
        end
        tick();
        chk("wdt_err", {ifc.err, ifc.busy, ifc.pp_en, ifc.alu_en}, 32'h8);
        ifc.pp_fin = 1'b1;
        tick();
        chk("wdt_err_sticky", {ifc.err, ifc.busy}, 32'h2);
        ifc.pp_fin = 1'b0;
        $display("step watchdog checks=%0d failures=%0d", checks, failures);
`endif

        // Random programs
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(0, 4095));
            do_reset();
            run_prog(40, 2);
            $display("step random_prog %0d checks=%0d failures=%0d", p, checks, failures);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
